// File: rtl/axi4lite_led_test_regs.sv
// AXI4-Lite register block (8-bit address, 16-bit data) that drives the LED and the
// 8-bit FPGA test bus, with a prescaled blink generator and a tick-driven test counter.
module axi4lite_led_test_regs #(
    parameter logic [15:0] ID_VALUE = 16'hF1D5,
    parameter int unsigned PRESCALE = 200
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic [7:0]  iv_S_AWADDR,
    input  logic        i_S_AWVALID,
    output logic        o_S_AWREADY,
    input  logic [15:0] iv_S_WDATA,
    input  logic [1:0]  iv_S_WSTRB,
    input  logic        i_S_WVALID,
    output logic        o_S_WREADY,
    output logic [1:0]  ov_S_BRESP,
    output logic        o_S_BVALID,
    input  logic        i_S_BREADY,
    input  logic [7:0]  iv_S_ARADDR,
    input  logic        i_S_ARVALID,
    output logic        o_S_ARREADY,
    output logic [15:0] ov_S_RDATA,
    output logic [1:0]  ov_S_RRESP,
    output logic        o_S_RVALID,
    input  logic        i_S_RREADY,
    output logic [7:0]  ov_FPGA_TEST,
    output logic        o_LED
);
    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_e;
    typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_e;

    function automatic logic [15:0] merge_strb(input logic [15:0] old_v,
                                               input logic [15:0] new_v,
                                               input logic [1:0]  strb);
        merge_strb = {strb[1] ? new_v[15:8] : old_v[15:8],
                      strb[0] ? new_v[7:0]  : old_v[7:0]};
    endfunction

    w_state_e    w_state_q;
    r_state_e    r_state_q;
    logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [15:0] rdata_q;
    logic [2:0]  ctrl_q;
    logic [15:0] blink_div_q, scratch_q, presc_q, blink_cnt_q;
    logic [7:0]  test_q, tcnt_q, test_out_q;
    logic        led_q;

    logic        wr_fire_s, tick_s, blink_clr_s, unused_s;
    logic [6:0]  wr_idx_s, rd_idx_s;
    logic [1:0]  wr_resp_s, rd_resp_s;
    logic [15:0] rd_data_s;

    assign wr_idx_s  = iv_S_AWADDR[7:1];
    assign rd_idx_s  = iv_S_ARADDR[7:1];
    assign wr_fire_s = (w_state_q == W_IDLE) && i_S_AWVALID && i_S_WVALID;
    assign wr_resp_s = (wr_idx_s <= 7'd4) ? 2'b00 : 2'b10;
    assign tick_s    = (presc_q == PRESC_MAX);
    assign unused_s  = ^{iv_S_AWADDR[0], iv_S_ARADDR[0]};
    // Blink phase restarts on any BLINK_DIV write or when BLINK is newly enabled
    assign blink_clr_s = wr_fire_s && ((wr_idx_s == 7'd2) ||
                         ((wr_idx_s == 7'd1) && iv_S_WSTRB[0] && iv_S_WDATA[1] && !ctrl_q[1]));

    // Read data/response mux over the current (pre-write) register values
    always_comb begin
        rd_data_s = 16'h0000;
        rd_resp_s = 2'b00;
        case (rd_idx_s)
            7'd0:    rd_data_s = ID_VALUE;
            7'd1:    rd_data_s = {13'h0000, ctrl_q};
            7'd2:    rd_data_s = blink_div_q;
            7'd3:    rd_data_s = {8'h00, test_q};
            7'd4:    rd_data_s = scratch_q;
            default: rd_resp_s = 2'b10;
        endcase
    end

    // Write channel FSM: accept AW+W together, then hold B until BREADY
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    bvalid_q  <= 1'b0;
                    awready_q <= wr_fire_s;
                    wready_q  <= wr_fire_s;
                    if (wr_fire_s) begin
                        bresp_q   <= wr_resp_s;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    if (bvalid_q && i_S_BREADY) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end else begin
                        bvalid_q <= 1'b1;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Register file updates on the accept edge, byte-masked by WSTRB
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            ctrl_q      <= 3'b000;
            blink_div_q <= 16'h0000;
            test_q      <= 8'h00;
            scratch_q   <= 16'h0000;
        end else if (wr_fire_s) begin
            case (wr_idx_s)
                7'd1:    if (iv_S_WSTRB[0]) ctrl_q <= iv_S_WDATA[2:0];
                7'd2:    blink_div_q <= merge_strb(blink_div_q, iv_S_WDATA, iv_S_WSTRB);
                7'd3:    if (iv_S_WSTRB[0]) test_q <= iv_S_WDATA[7:0];
                7'd4:    scratch_q <= merge_strb(scratch_q, iv_S_WDATA, iv_S_WSTRB);
                default: scratch_q <= scratch_q;
            endcase
        end
    end

    // Read channel FSM, independent of the write side
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 16'h0000;
            rresp_q   <= 2'b00;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    rvalid_q  <= 1'b0;
                    arready_q <= i_S_ARVALID;
                    if (i_S_ARVALID) begin
                        rdata_q   <= rd_data_s;
                        rresp_q   <= rd_resp_s;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    arready_q <= 1'b0;
                    if (rvalid_q && i_S_RREADY) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end else begin
                        rvalid_q <= 1'b1;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Free-running prescaler producing a one-cycle tick every PRESCALE clocks
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) presc_q <= 16'h0000;
        else         presc_q <= tick_s ? 16'h0000 : presc_q + 16'h0001;
    end

    // LED: off, steady on, or toggling every BLINK_DIV+1 ticks
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            blink_cnt_q <= 16'h0000;
            led_q       <= 1'b0;
        end else begin
            if (blink_clr_s)
                blink_cnt_q <= 16'h0000;
            else if (ctrl_q[0] && ctrl_q[1] && tick_s)
                blink_cnt_q <= (blink_cnt_q == blink_div_q) ? 16'h0000 : blink_cnt_q + 16'h0001;

            if (!ctrl_q[0])
                led_q <= 1'b0;
            else if (!ctrl_q[1])
                led_q <= 1'b1;
            else if (!blink_clr_s && tick_s && (blink_cnt_q == blink_div_q))
                led_q <= ~led_q;
        end
    end

    // Test bus: static TEST byte, or a tick counter that holds while disabled
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            tcnt_q     <= 8'h00;
            test_out_q <= 8'h00;
        end else begin
            if (ctrl_q[2] && tick_s) tcnt_q <= tcnt_q + 8'h01;
            test_out_q <= ctrl_q[2] ? tcnt_q : test_q;
        end
    end

    assign o_S_AWREADY  = awready_q;
    assign o_S_WREADY   = wready_q;
    assign o_S_BVALID   = bvalid_q;
    assign ov_S_BRESP   = bresp_q;
    assign o_S_ARREADY  = arready_q;
    assign o_S_RVALID   = rvalid_q;
    assign ov_S_RDATA   = rdata_q;
    assign ov_S_RRESP   = rresp_q;
    assign o_LED        = led_q;
    assign ov_FPGA_TEST = test_out_q;
endmodule

// File: doc/axi4lite_led_test_regs.md
Name: axi4lite_led_test_regs

Overview:
- AXI4-Lite slave register block (8-bit address, 16-bit data) driven by the AXI Lite master BFM channel.
- Decodes control registers and produces the LED drive and 8-bit FPGA test bus that feed the top-level DUT (o_LED, ov_FPGA_TEST).
- Contains a prescaled blink generator and a test-pattern counter, so the bench can exercise the DUT outputs through register writes.

Parameters:
- ID_VALUE, 16'hF1D5: constant returned by the ID register.
- PRESCALE, 200: i_CLK cycles per tick. Legal range is 1..65535.

Ports:
- i_CLK  in  1  system clock
- i_RESET  in  1  asynchronous, active-high reset
- iv_S_AWADDR  in  8  write address
- i_S_AWVALID  in  1  write address valid
- o_S_AWREADY  out  1  write address ready
- iv_S_WDATA  in  16  write data
- iv_S_WSTRB  in  2  byte strobes
- i_S_WVALID  in  1  write data valid
- o_S_WREADY  out  1  write data ready
- ov_S_BRESP  out  2  write response
- o_S_BVALID  out  1  write response valid
- i_S_BREADY  in  1  write response ready
- iv_S_ARADDR  in  8  read address
- i_S_ARVALID  in  1  read address valid
- o_S_ARREADY  out  1  read address ready
- ov_S_RDATA  out  16  read data
- ov_S_RRESP  out  2  read response
- o_S_RVALID  out  1  read valid
- i_S_RREADY  in  1  read ready
- ov_FPGA_TEST  out  8  test bus to DUT
- o_LED  out  1  LED drive to DUT

Behaviour:
- Clock and reset: one clock domain, i_CLK. i_RESET is asynchronous and active-high; it clears all state immediately.
- Reset values:
  - all READY/VALID outputs 0; BRESP and RRESP 2'b00; RDATA 0
  - o_LED 0; ov_FPGA_TEST 8'h00
  - CTRL 0; BLINK_DIV 0; TEST 0; SCRATCH 0; prescaler and counters 0
- Register map (byte address; bit 0 is ignored for decode):
  - 0x00 ID, read-only, returns ID_VALUE
  - 0x02 CTRL, R/W, bits [2:0]: bit0 LED_EN, bit1 BLINK, bit2 TEST_CNT; bits [15:3] read as 0
  - 0x04 BLINK_DIV, R/W, 16 bits
  - 0x06 TEST, R/W, bits [7:0]; upper bits read as 0
  - 0x08 SCRATCH, R/W, 16 bits
  - any other address: SLVERR (2'b10); reads return 0; writes have no effect
  - a write to ID returns OKAY and is ignored
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: when AWVALID and WVALID are both 1, pulse AWREADY and WREADY together for exactly 1 cycle. In that same edge, update the register per WSTRB (bit0 -> [7:0], bit1 -> [15:8]), then go to W_RESP.
  - W_RESP: hold BVALID=1 and BRESP stable until BREADY=1, then return to W_IDLE.
  - AW without W (or W without AW) is held off: no READY is asserted.
  - Minimum write cycle: 3 clocks (accept, BVALID, handshake).
- Read FSM, states R_IDLE and R_DATA, independent of the write FSM:
  - R_IDLE: when ARVALID=1, pulse ARREADY for 1 cycle, capture RDATA and RRESP from register values before any same-edge write, then go to R_DATA.
  - R_DATA: hold RVALID, RDATA and RRESP stable until RREADY=1.
- Tick generator:
  - prescaler counts 0..PRESCALE-1 and pulses tick when it wraps
  - runs continuously after reset
- LED (registered):
  - LED_EN=0: o_LED=0
  - LED_EN=1, BLINK=0: o_LED=1
  - LED_EN=1, BLINK=1: o_LED toggles every BLINK_DIV+1 ticks. BLINK_DIV=0 means a toggle every tick.
  - A write to BLINK_DIV, or a 0->1 transition of BLINK, clears the blink count; o_LED keeps its current level.
- Test bus (registered):
  - TEST_CNT=0: ov_FPGA_TEST = TEST[7:0] one cycle after the write edge
  - TEST_CNT=1: an 8-bit counter increments on each tick and wraps 8'hFF -> 8'h00, with ov_FPGA_TEST = counter
  - The counter holds its value while TEST_CNT=0 and resumes from that value when re-enabled.
- Reset mid-transaction: any pending BVALID/RVALID is dropped immediately and registers return to their reset values. The master must reissue the transaction.

Test Plan:
- Reset, then read 0x00 -> RDATA=16'hF1D5, RRESP=00. Read 0x02 -> 0x0000. During reset, o_LED=0 and ov_FPGA_TEST=8'h00.
- Write 0x06=16'h00A5, WSTRB=2'b01 -> BRESP=00. ov_FPGA_TEST=8'hA5 one cycle after the write edge. Readback=16'h00A5.
- Write 0x08=16'h1234, then write 16'hABCD with WSTRB=2'b10 -> SCRATCH reads 16'hAB34.
- PRESCALE=4, BLINK_DIV=2, CTRL=3'b011 -> o_LED toggles every 12 i_CLK cycles. CTRL=3'b001 -> o_LED steady 1.
- PRESCALE=4, CTRL=3'b100 -> ov_FPGA_TEST increments every 4 clocks. After 256 ticks it returns to its start value (wrap check).
- Read 0x0A and write 0x20 -> RRESP=BRESP=2'b10, RDATA=0. Hold BREADY low 5 cycles -> BVALID stays 1. Assert i_RESET mid-R_DATA -> RVALID=0 immediately.
